// File: rtl/rr_grant_ctrl4.sv
// Four-way round-robin grant sequencer with a bounded hold time per grant.
// Drives a registered one-hot select plus owner index, valid and a preempt pulse.
module rr_grant_ctrl4 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic [3:0] req_i,
    output logic [3:0] gnt_o,
    output logic [1:0] gnt_idx_o,
    output logic       gnt_vld_o,
    output logic       preempt_o
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state_q;
    logic [1:0]       ptr_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic [3:0]       gnt_q;
    logic [1:0]       gnt_idx_q;
    logic             gnt_vld_q;
    logic             preempt_q;

    logic       win_vld;
    logic [1:0] win_idx;
    logic [1:0] scan_idx;
    logic       own_req;
    logic       hold_done;

    // Scan from the farthest candidate back to ptr so the nearest requester wins.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = ptr_q;
        scan_idx = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            scan_idx = ptr_q + 2'(k);
            if (req_i[scan_idx]) begin
                win_vld = 1'b1;
                win_idx = scan_idx;
            end
        end
    end

    assign own_req   = req_i[gnt_idx_q];
    assign hold_done = (hold_cnt_q == CNT_W'(MAX_HOLD));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            ptr_q      <= 2'd0;
            hold_cnt_q <= '0;
            gnt_q      <= 4'b0000;
            gnt_idx_q  <= 2'd0;
            gnt_vld_q  <= 1'b0;
            preempt_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    preempt_q <= 1'b0;
                    if (en_i && win_vld) begin
                        state_q    <= GRANT;
                        gnt_idx_q  <= win_idx;
                        gnt_q      <= 4'b0001 << win_idx;
                        gnt_vld_q  <= 1'b1;
                        hold_cnt_q <= CNT_W'(1);
                    end
                end
                GRANT: begin
                    if (!own_req || !en_i || hold_done) begin
                        state_q    <= IDLE;
                        gnt_q      <= 4'b0000;
                        gnt_vld_q  <= 1'b0;
                        ptr_q      <= gnt_idx_q + 2'd1;
                        hold_cnt_q <= '0;
                        // Only a forced revocation of a still-requesting owner counts as preemption.
                        preempt_q  <= own_req && en_i && hold_done;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_idx_o = gnt_idx_q;
    assign gnt_vld_o = gnt_vld_q;
    assign preempt_o = preempt_q;

endmodule

// File: tb/tb_rr_grant_ctrl4.sv
// Directed bench for rr_grant_ctrl4: one instance with the default hold limit,
// one with a hold limit of 2 for the rotation scenario; both share the inputs.
module tb_rr_grant_ctrl4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] req;

    logic [3:0] gnt8, gnt2;
    logic [1:0] idx8, idx2;
    logic       vld8, vld2;
    logic       pre8, pre2;

    int n_pass  = 0;
    int n_total = 0;

    rr_grant_ctrl4 #(.MAX_HOLD(8), .CNT_W(8)) dut8 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .req_i(req),
        .gnt_o(gnt8), .gnt_idx_o(idx8), .gnt_vld_o(vld8), .preempt_o(pre8)
    );

    rr_grant_ctrl4 #(.MAX_HOLD(2), .CNT_W(8)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .req_i(req),
        .gnt_o(gnt2), .gnt_idx_o(idx2), .gnt_vld_o(vld2), .preempt_o(pre2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        en    = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        logic [7:0] exp_v;
        rst_n = 1'b0;
        req   = 4'b1111;
        en    = 1'b1;
        tick();
        tick();
        exp_v = 8'b0000_00_0_0;
        n_total++;
        if ({gnt8, idx8, vld8, pre8} !== exp_v)
            $display("FAIL reset_dut8 got %b want %b", {gnt8, idx8, vld8, pre8}, exp_v);
        else n_pass++;
        n_total++;
        if ({gnt2, idx2, vld2, pre2} !== exp_v)
            $display("FAIL reset_dut2 got %b want %b", {gnt2, idx2, vld2, pre2}, exp_v);
        else n_pass++;
        rst_n = 1'b1;
        tick();
        exp_v = {4'b0001, 2'd0, 1'b1, 1'b0};
        n_total++;
        if ({gnt8, idx8, vld8, pre8} !== exp_v)
            $display("FAIL reset_first_grant got %b want %b", {gnt8, idx8, vld8, pre8}, exp_v);
        else n_pass++;
    endtask

    task automatic test_hold_expiry();
        logic [7:0] exp_v;
        do_reset();
        req   = 4'b0100;
        rst_n = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (((k - 1) % 9) < 8) exp_v = {4'b0100, 2'd2, 1'b1, 1'b0};
            else                   exp_v = {4'b0000, 2'd2, 1'b0, 1'b1};
            n_total++;
            if ({gnt8, idx8, vld8, pre8} !== exp_v)
                $display("FAIL hold_expiry k=%0d got %b want %b", k, {gnt8, idx8, vld8, pre8}, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_v;
        logic [1:0] owner;
        do_reset();
        req   = 4'b1111;
        rst_n = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            owner = 2'(((k - 1) / 3) % 4);
            if (((k - 1) % 3) < 2) exp_v = {4'b0001 << owner, owner, 1'b1, 1'b0};
            else                   exp_v = {4'b0000, owner, 1'b0, 1'b1};
            n_total++;
            if ({gnt2, idx2, vld2, pre2} !== exp_v || !$onehot0(gnt2))
                $display("FAIL round_robin k=%0d got %b want %b", k, {gnt2, idx2, vld2, pre2}, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_early_release();
        logic [7:0] exp_v;
        do_reset();
        req   = 4'b0010;
        rst_n = 1'b1;
        tick();
        req = 4'b1011;
        tick();
        tick();
        exp_v = {4'b0010, 2'd1, 1'b1, 1'b0};
        n_total++;
        if ({gnt8, idx8, vld8, pre8} !== exp_v)
            $display("FAIL early_hold got %b want %b", {gnt8, idx8, vld8, pre8}, exp_v);
        else n_pass++;
        req = 4'b1001;
        tick();
        exp_v = {4'b0000, 2'd1, 1'b0, 1'b0};
        n_total++;
        if ({gnt8, idx8, vld8, pre8} !== exp_v)
            $display("FAIL early_release got %b want %b", {gnt8, idx8, vld8, pre8}, exp_v);
        else n_pass++;
        tick();
        exp_v = {4'b1000, 2'd3, 1'b1, 1'b0};
        n_total++;
        if ({gnt8, idx8, vld8, pre8} !== exp_v)
            $display("FAIL early_next_owner got %b want %b", {gnt8, idx8, vld8, pre8}, exp_v);
        else n_pass++;
    endtask

    task automatic test_enable_gating();
        logic [7:0] exp_v;
        do_reset();
        req   = 4'b0100;
        rst_n = 1'b1;
        tick();
        exp_v = {4'b0100, 2'd2, 1'b1, 1'b0};
        n_total++;
        if ({gnt8, idx8, vld8, pre8} !== exp_v)
            $display("FAIL en_grant got %b want %b", {gnt8, idx8, vld8, pre8}, exp_v);
        else n_pass++;
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_v = {4'b0000, 2'd2, 1'b0, 1'b0};
            n_total++;
            if ({gnt8, idx8, vld8, pre8} !== exp_v)
                $display("FAIL en_low k=%0d got %b want %b", k, {gnt8, idx8, vld8, pre8}, exp_v);
            else n_pass++;
        end
        en = 1'b1;
        tick();
        exp_v = {4'b0100, 2'd2, 1'b1, 1'b0};
        n_total++;
        if ({gnt8, idx8, vld8, pre8} !== exp_v)
            $display("FAIL en_regrant got %b want %b", {gnt8, idx8, vld8, pre8}, exp_v);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [7:0] exp_v;
        do_reset();
        req   = 4'b0010;
        rst_n = 1'b1;
        tick();
        req = 4'b0000;
        tick();
        req = 4'b0010;
        tick();
        exp_v = {4'b0010, 2'd1, 1'b1, 1'b0};
        n_total++;
        if ({gnt8, idx8, vld8, pre8} !== exp_v)
            $display("FAIL async_pre_grant got %b want %b", {gnt8, idx8, vld8, pre8}, exp_v);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        exp_v = 8'b0000_00_0_0;
        n_total++;
        if ({gnt8, idx8, vld8, pre8} !== exp_v)
            $display("FAIL async_clear got %b want %b", {gnt8, idx8, vld8, pre8}, exp_v);
        else n_pass++;
        req = 4'b0110;
        #2;
        rst_n = 1'b1;
        tick();
        exp_v = {4'b0010, 2'd1, 1'b1, 1'b0};
        n_total++;
        if ({gnt8, idx8, vld8, pre8} !== exp_v)
            $display("FAIL async_restart got %b want %b", {gnt8, idx8, vld8, pre8}, exp_v);
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 4'b0000;
        test_reset();
        test_hold_expiry();
        test_round_robin();
        test_early_release();
        test_enable_gating();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
